// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider (seq_divider, div_step).
`ifndef WORD
`define WORD 64
`endif

package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int unsigned DIV_WIDTH = `WORD;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  // Counter width for an arbitrary operand width; at least one bit.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: shift {rem, quo} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [2*WIDTH:0] cat_sh;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    cat_sh = {rem_i, quo_i} << 1;
    rem_sh = cat_sh[2*WIDTH:WIDTH];
    quo_sh = cat_sh[WIDTH-1:0];
    // One extra bit beyond the partial remainder makes the borrow explicit.
    diff   = {1'b0, rem_sh} - {2'b00, dvs_i};
    borrow = diff[WIDTH+1];
    rem_o  = borrow ? rem_sh : diff[WIDTH:0];
    quo_o  = quo_sh | {{(WIDTH-1){1'b0}}, ~borrow};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Optional signed support via `SIGNED_DIV_EN (adds signed_in and sign fix-up).
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
`ifdef SIGNED_DIV_EN
  input  logic             signed_in,
`endif
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             div_zero_out
);

  localparam int unsigned CNT_W = div_cnt_w(WIDTH);

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             dz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

`ifdef SIGNED_DIV_EN
  logic neg_q_q;
  logic neg_r_q;
  logic dvd_neg;
  logic dvs_neg;

  always_comb begin
    dvd_neg = signed_in & dividend_in[WIDTH-1];
    dvs_neg = signed_in & divisor_in[WIDTH-1];
    dvd_mag = dvd_neg ? ('0 - dividend_in) : dividend_in;
    dvs_mag = dvs_neg ? ('0 - divisor_in) : divisor_in;
    quo_fix = neg_q_q ? ('0 - quo_q) : quo_q;
    rem_fix = neg_r_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
  end
`else
  always_comb begin
    dvd_mag = dividend_in;
    dvs_mag = divisor_in;
    quo_fix = quo_q;
    rem_fix = rem_q[WIDTH-1:0];
  end
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_in) begin
            dvs_q  <= dvs_mag;
            busy_q <= 1'b1;
`ifdef SIGNED_DIV_EN
            neg_q_q <= dvd_neg ^ dvs_neg;
            neg_r_q <= dvd_neg;
`endif
            // Zero divisor parks the dividend in the remainder so FIXUP
            // produces the ARM result (q=0, r=dividend) through the normal path.
            if (divisor_in == '0) begin
              dz_q    <= 1'b1;
              rem_q   <= {1'b0, dvd_mag};
              quo_q   <= '0;
              cnt_q   <= '0;
              state_q <= FIXUP;
            end else begin
              dz_q    <= 1'b0;
              rem_q   <= '0;
              quo_q   <= dvd_mag;
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt_q == '0) begin
            state_q <= FIXUP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIXUP: begin
          quotient_q  <= quo_fix;
          remainder_q <= rem_fix;
          div_zero_q  <= dz_q;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient_out  = quotient_q;
  assign remainder_out = remainder_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign div_zero_out  = div_zero_q;

endmodule
